// File: rtl/shift_pair_unit.sv
// Chained right-shift pair A->B with single-step or counted burst shifting.
// Loads/single shifts visible next cycle; burst of n ends with Done n+1 edges after start; no backpressure.
module shift_pair_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr_A,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  input  logic             Shift_En,
  input  logic             Shift_Start,
  input  logic [CNT_W-1:0] Shift_Count,
  input  logic             Arith,
  input  logic             X_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_out,
  output logic             B_out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_cap;
  logic             load_any;
  logic             do_shift;
  logic             fill;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    do_shift = 1'b0;
    load_any = Clr_A | Ld_A | Ld_B;
    fill     = Arith ? a_q[WIDTH-1] : X_In;
    cnt_cap  = (Shift_Count > CNT_MAX) ? CNT_MAX : Shift_Count;

    case (state_q)
      S_SHIFT: begin
        do_shift = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        // Any load/clear in the same cycle suppresses both single shift and start.
        if (!load_any) begin
          if (Shift_En) begin
            do_shift = 1'b1;
          end else if (Shift_Start) begin
            cnt_d   = cnt_cap;
            state_d = (cnt_cap == '0) ? S_DONE : S_SHIFT;
          end
        end
      end
    endcase

    if (state_q != S_SHIFT) begin
      if (Ld_A)  a_d = DA;
      if (Clr_A) a_d = '0;
      if (Ld_B)  b_d = DB;
    end

    if (do_shift) begin
      a_d = {fill, a_q[WIDTH-1:1]};
      b_d = {a_q[0], b_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign A_out = a_q[0];
  assign B_out = b_q[0];
  assign Busy  = (state_q == S_SHIFT);
  assign Done  = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_pair_unit.sv
// Randomised and directed bench for shift_pair_unit with a Done-driven scoreboard.
module tb_shift_pair_unit;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Clr_A = 0, Ld_A = 0, Ld_B = 0, Shift_En = 0, Shift_Start = 0;
  logic [W-1:0]  DA = '0, DB = '0;
  logic [CW-1:0] Shift_Count = '0;
  logic          Arith = 0, X_In = 0;
  logic [W-1:0]  A, B;
  logic          A_out, B_out, Busy, Done;

  shift_pair_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Clr_A(Clr_A), .Ld_A(Ld_A), .Ld_B(Ld_B),
    .DA(DA), .DB(DB), .Shift_En(Shift_En), .Shift_Start(Shift_Start),
    .Shift_Count(Shift_Count), .Arith(Arith), .X_In(X_In),
    .A(A), .B(B), .A_out(A_out), .B_out(B_out), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] m_a = '0, m_b = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference view: {A,B} is one 2W-bit word shifted right with a chosen top bit.
  function automatic logic [2*W-1:0] ref_shift(input logic [2*W-1:0] ab, input logic ar, input logic x);
    logic top;
    top = ar ? ab[2*W-1] : x;
    return (ab >> 1) | ({{(2*W-1){1'b0}}, top} << (2*W-1));
  endfunction

  task automatic model_step(input logic ar, input logic x);
    logic [2*W-1:0] ab;
    ab = ref_shift({m_a, m_b}, ar, x);
    m_a = ab[2*W-1:W];
    m_b = ab[W-1:0];
  endtask

  // Monitor: every Done pulse retires one expected burst result.
  int run_len = 0;
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset) begin
        run_len = 0;
      end else if (Done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(Done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_a", 32'(A), 32'(e.a));
          check("done_b", 32'(B), 32'(e.b));
          check("busy_len", 32'(run_len), 32'(e.n));
          check("busy_in_done", 32'(Busy), 32'd0);
        end
        run_len = 0;
      end else if (Busy) begin
        run_len++;
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic load_ab(input logic la, input logic [W-1:0] a, input logic lb, input logic [W-1:0] b, input logic clr);
    @(posedge Clk); #1;
    Ld_A = la; DA = a; Ld_B = lb; DB = b; Clr_A = clr;
    @(posedge Clk); #1;
    Ld_A = 0; Ld_B = 0; Clr_A = 0;
    if (la)  m_a = a;
    if (clr) m_a = '0;
    if (lb)  m_b = b;
    @(negedge Clk);
    check("load_a", 32'(A), 32'(m_a));
    check("load_b", 32'(B), 32'(m_b));
  endtask

  task automatic single_shift(input logic ar, input logic x);
    @(posedge Clk); #1;
    Shift_En = 1; Arith = ar; X_In = x;
    @(posedge Clk); #1;
    Shift_En = 0;
    model_step(ar, x);
    @(negedge Clk);
    check("single_a", 32'(A), 32'(m_a));
    check("single_b", 32'(B), 32'(m_b));
    check("single_aout", 32'(A_out), 32'(m_a[0]));
    check("single_bout", 32'(B_out), 32'(m_b[0]));
    check("single_nodone", 32'(Done), 32'd0);
  endtask

  // disturb: pulse loads/shift/start mid-burst and Start in the DONE cycle.
  // abort_at: assert Reset asynchronously after that many shifts (0 = never).
  task automatic burst(input int n, input logic ar, input logic x, input bit disturb, input int abort_at);
    int   eff;
    exp_t e;
    eff = (n > W) ? W : n;
    @(posedge Clk); #1;
    Shift_Start = 1; Shift_Count = CW'(n); Arith = ar; X_In = x;
    @(posedge Clk); #1;
    Shift_Start = 0;
    begin
      logic [W-1:0] sa, sb;
      sa = m_a; sb = m_b;
      for (int i = 0; i < eff; i++) model_step(ar, x);
      e.a = m_a; e.b = m_b; e.n = eff;
      exp_q.push_back(e);
      m_a = sa; m_b = sb;
    end
    @(negedge Clk);
    if (eff == 0) begin
      check("n0_done", 32'(Done), 32'd1);
      check("n0_busy", 32'(Busy), 32'd0);
      return;
    end
    check("burst_busy0", 32'(Busy), 32'd1);
    for (int i = 1; i <= eff; i++) begin
      @(posedge Clk);
      model_step(ar, x);
      #1;
      if (abort_at == i) begin
        Reset = 1;
        #1;
        check("abort_a", 32'(A), 32'd0);
        check("abort_b", 32'(B), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        void'(exp_q.pop_back());
        m_a = '0; m_b = '0;
        @(posedge Clk); #1;
        Reset = 0;
        return;
      end
      if (disturb && i == 2) begin
        Ld_A = 1; DA = 8'h11; Clr_A = 1; Ld_B = 1; DB = 8'h22;
        Shift_En = 1; Shift_Start = 1; Shift_Count = CW'(1);
      end
      if (disturb && i == 3) begin
        Ld_A = 0; Clr_A = 0; Ld_B = 0; Shift_En = 0; Shift_Start = 0;
      end
      if (disturb && i == eff) begin
        Shift_Start = 1; Shift_Count = CW'(2);
      end
      @(negedge Clk);
      check("step_a", 32'(A), 32'(m_a));
      check("step_b", 32'(B), 32'(m_b));
      if (i < eff) check("step_busy", 32'(Busy), 32'd1);
      else         check("end_done", 32'(Done), 32'd1);
    end
    if (disturb) begin
      @(posedge Clk); #1;
      Shift_Start = 0;
      @(negedge Clk);
      check("donecyc_start_busy", 32'(Busy), 32'd0);
      check("donecyc_start_done", 32'(Done), 32'd0);
      check("donecyc_a", 32'(A), 32'(m_a));
    end
  endtask

  initial begin
    #1;
    check("rst_a", 32'(A), 32'd0);
    check("rst_b", 32'(B), 32'd0);
    check("rst_outs", 32'({A_out, B_out, Busy, Done}), 32'd0);
    @(posedge Clk); #1;
    Reset = 0;
    @(negedge Clk);
    check("idle_outs", 32'({A, B, A_out, B_out, Busy, Done}), 32'd0);

    load_ab(1, 8'hA5, 1, 8'h00, 0);
    burst(8, 0, 0, 0, 0);
    check("t2_a", 32'(A), 32'h00);
    check("t2_b", 32'(B), 32'hA5);

    load_ab(1, 8'h96, 1, 8'h3C, 0);
    burst(3, 1, 0, 0, 0);
    check("t3_a", 32'(A), 32'hF2);
    check("t3_b", 32'(B), 32'hC7);

    load_ab(1, 8'hFF, 1, 8'h00, 0);
    burst(12, 0, 1, 0, 0);
    check("clamp_a", 32'(A), 32'hFF);
    check("clamp_b", 32'(B), 32'hFF);
    burst(0, 0, 0, 0, 0);
    @(negedge Clk);
    check("n0_a", 32'(A), 32'hFF);

    load_ab(1, 8'h5A, 1, 8'h33, 0);
    burst(5, 0, 1, 1, 0);

    load_ab(1, 8'h3C, 0, 8'h00, 1);
    check("clr_wins", 32'(A), 32'd0);

    // Start blocked by a same-cycle Ld_B.
    @(posedge Clk); #1;
    Shift_Start = 1; Shift_Count = CW'(3); Ld_B = 1; DB = 8'h9E;
    @(posedge Clk); #1;
    Shift_Start = 0; Ld_B = 0; m_b = 8'h9E;
    @(negedge Clk);
    check("blocked_busy", 32'(Busy), 32'd0);
    check("blocked_b", 32'(B), 32'h9E);

    load_ab(1, 8'hC3, 1, 8'h18, 0);
    burst(5, 1, 0, 0, 2);
    repeat (3) @(negedge Clk);
    check("post_abort_busy", 32'(Busy), 32'd0);
    load_ab(1, 8'h81, 1, 8'h7E, 0);
    burst(4, 0, 1, 0, 0);

    for (int it = 0; it < 30; it++) begin
      load_ab(1, W'($urandom), 1, W'($urandom), 0);
      if ($urandom_range(0, 3) == 0) single_shift(1'($urandom), 1'($urandom));
      else burst(int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 0, 0);
    end

    repeat (4) @(negedge Clk);
    check("pending_done", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
